seq_shifter: RTL and testbench
==============================

// Module: seq_shifter
// PURPOSE
//   Multi-cycle shift unit. Shifts by a variable amount, one bit position per clock.
//   Reuses the datapath shifter op encoding (00 none, 01 LSL, 10 LSR, 11 ASR).
//   A start/busy/done handshake lets the controller FSM issue multi-bit shifts.
//   Supports an optional rotate mode.
// PARAMETERS
//   WIDTH  16  data width of in/sout
//   AMT_W  4   width of shift amount; max amount = 2**AMT_W-1
// PORTS
//   clk    in   1      rising-edge clock, single clock domain
//   rst_n  in   1      asynchronous, active-low reset
//   start  in   1      request; sampled only in IDLE
//   in     in   WIDTH  operand, latched on accepted start
//   op     in   2      00 none, 01 LSL, 10 LSR, 11 ASR; latched on accepted start
//   amt    in   AMT_W  shift distance, latched on accepted start
//   rot    in   1      rotate select, latched on accepted start; ignored unless SEQ_SHIFTER_ROT_EN
//   busy   out  1      high while state==SHIFT
//   done   out  1      one-cycle pulse; sout holds the final result in this cycle
//   sout   out  WIDTH  working/result register
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, sout=0, busy=0, done=0, count=0; takes effect immediately, including mid-shift.
//   FSM states IDLE, SHIFT, DONE. busy=(state==SHIFT); done=(state==DONE).
//   IDLE, start=1 at edge E0: sout<=in, count<=amt, op/rot latched.
//     Next state is DONE if op==00 or amt==0, else SHIFT.
//   SHIFT, each edge: sout<=one-bit shift of sout per latched op, count<=count-1.
//     Next state is DONE when count==1, else stay in SHIFT.
//   DONE: next state is IDLE unconditionally. start is ignored in SHIFT and DONE.
//   Latency: done is high in the cycle after edge E0+amt, i.e. amt+1 cycles after start.
//     With op==00 or amt==0, done follows 1 cycle after start and sout==in.
//   Per-bit shift ops:
//     LSL: {sout[W-2:0],1'b0}
//     LSR: {1'b0,sout[W-1:1]}
//     ASR: {sout[W-1],sout[W-1:1]}; sign fills for any amt, up to 15.
//   sout is valid from the done cycle until the next accepted start (held in IDLE).
//   Back-to-back ops: the earliest next start is accepted in the IDLE cycle after done.
//   Inputs in/op/amt/rot may change freely after an accepted start.
// CONFIGURATION
//   SEQ_SHIFTER_ROT_EN defined:
//     rot=1 with op=01 performs rotate left: {sout[W-2:0],sout[W-1]}.
//     rot=1 with op=10 performs rotate right: {sout[0],sout[W-1:1]}.
//     rot has no effect for op=00 or op=11.
//   SEQ_SHIFTER_ROT_EN undefined: rot is ignored; the port is still present.
// TESTING
//   1. in=16'hF0CF, op=00, amt=5, start -> done after 1 cycle, sout=16'hF0CF, busy never high.
//   2. in=16'hF0CF, amt=1 for op=01/10/11 -> sout=16'hE19E / 16'h7867 / 16'hF867, done 2 cycles after start.
//   3. in=16'hF0CF, amt=4, op=11 -> sout=16'hFF0C; op=10 -> 16'h0F0C; busy high for exactly 4 cycles.
//   4. in=16'h0001, op=01, amt=15 -> sout=16'h8000 at done, 16 cycles after start.
//      A second start issued while busy is ignored.
//   5. Rotate: in=16'hF0CF, op=01, amt=4, rot=1 -> 16'h0CFF with SEQ_SHIFTER_ROT_EN defined, 16'h0CF0 without it.
//   6. rst_n=0 mid-SHIFT -> busy=0, done=0, sout=0 immediately.
//      After release, a new start behaves per case 2.

Source files
------------

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle one-bit-per-clock shifter with start/busy/done handshake
// Optional rotate mode for LSL/LSR is enabled by defining SEQ_SHIFTER_ROT_EN.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic             rot,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [AMT_W-1:0]   count;
  logic [1:0]         op_q;
  logic               rot_on;
  logic [WIDTH-1:0]   shifted;

`ifdef SEQ_SHIFTER_ROT_EN
  logic rot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q <= 1'b0;
    end else if (state == IDLE && start) begin
      rot_q <= rot;
    end
  end

  assign rot_on = rot_q;
`else
  // rot is kept on the port for pin compatibility but has no function here.
  logic rot_unused;
  assign rot_unused = rot;
  assign rot_on     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == 2'b00 || amt == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (count == AMT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Rotate only changes the fill bit of the logical shifts; ASR ignores it.
  always_comb begin
    shifted = sout;
    case (op_q)
      2'b01:   shifted = {sout[WIDTH-2:0], (rot_on ? sout[WIDTH-1] : 1'b0)};
      2'b10:   shifted = {(rot_on ? sout[0] : 1'b0), sout[WIDTH-1:1]};
      2'b11:   shifted = {sout[WIDTH-1], sout[WIDTH-1:1]};
      default: shifted = sout;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sout  <= '0;
      count <= '0;
      op_q  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sout  <= in;
            count <= amt;
            op_q  <= op;
          end
        end
        SHIFT: begin
          sout  <= shifted;
          count <= count - AMT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - self-checking bench for seq_shifter against a behavioural model
// Honours SEQ_SHIFTER_ROT_EN to pick the expected rotate behaviour.
module tb_seq_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] in_d;
  logic [1:0]  op_d;
  logic [3:0]  amt_d;
  logic        rot_d;
  logic        busy;
  logic        done;
  logic [15:0] sout;

  int tests;
  int fails;

`ifdef SEQ_SHIFTER_ROT_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  seq_shifter #(.WIDTH(16), .AMT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (in_d),
    .op    (op_d),
    .amt   (amt_d),
    .rot   (rot_d),
    .busy  (busy),
    .done  (done),
    .sout  (sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of shifting x by n whole positions, computed arithmetically.
  function automatic logic [15:0] mshift(logic [15:0] x, logic [1:0] o, logic r, int n);
    logic [15:0] res;
    case (o)
      2'b01: res = (ROT_EN && r && n != 0) ? ((x << n) | (x >> (16 - n))) : (x << n);
      2'b10: res = (ROT_EN && r && n != 0) ? ((x >> n) | (x << (16 - n))) : (x >> n);
      2'b11: res = 16'($signed(x) >>> n);
      default: res = x;
    endcase
    return res;
  endfunction

  // Model: k counts cycles since the accepted start (0 = never started);
  // the transaction occupies cycles 1..lat, done in cycle lat, idle after.
  int          m_k;
  int          m_lat;
  logic [15:0] m_in;
  logic [1:0]  m_op;
  logic        m_rot;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0;
      m_lat = 1;
    end else if (m_k == 0 || m_k > m_lat) begin
      if (start) begin
        m_k   = 1;
        m_in  = in_d;
        m_op  = op_d;
        m_rot = rot_d;
        m_lat = (op_d == 2'b00 || amt_d == 4'd0) ? 1 : int'(amt_d) + 1;
      end
    end else begin
      m_k = m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int n;
      n = (m_k >= m_lat) ? m_lat - 1 : m_k - 1;
      check("busy", 32'(busy), 32'(m_k >= 1 && m_k < m_lat));
      check("done", 32'(done), 32'(m_k >= 1 && m_k == m_lat));
      check("sout", 32'(sout), (m_k == 0) ? 32'd0 : 32'(mshift(m_in, m_op, m_rot, n)));
    end
  end

  task automatic do_op(input logic [15:0] i, input logic [1:0] o, input logic [3:0] a,
                       input logic r, input logic [15:0] exp, input int lat, input bit poke);
    int cyc;
    int nb;
    @(posedge clk); #1;
    start = 1'b1; in_d = i; op_d = o; amt_d = a; rot_d = r;
    @(posedge clk); #1;
    start = 1'b0;
    in_d = 16'($urandom); op_d = 2'($urandom); amt_d = 4'($urandom); rot_d = 1'($urandom);
    cyc = 1;
    nb  = 0;
    while (!done && cyc < 40) begin
      if (busy) nb++;
      if (poke && cyc == 3) begin
        start = 1'b1; in_d = 16'hFFFF; op_d = 2'b10; amt_d = 4'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check("op_done_seen", 32'(done), 32'd1);
    check("op_latency", 32'(cyc), 32'(lat));
    check("op_busy_cycles", 32'(nb), 32'(lat - 1));
    check("op_result", 32'(sout), 32'(exp));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    in_d  = '0;
    op_d  = '0;
    amt_d = '0;
    rot_d = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sout", 32'(sout), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    do_op(16'hF0CF, 2'b00, 4'd5, 1'b0, 16'hF0CF, 1, 1'b0);
    do_op(16'hF0CF, 2'b01, 4'd1, 1'b0, 16'hE19E, 2, 1'b0);
    do_op(16'hF0CF, 2'b10, 4'd1, 1'b0, 16'h7867, 2, 1'b0);
    do_op(16'hF0CF, 2'b11, 4'd1, 1'b0, 16'hF867, 2, 1'b0);
    do_op(16'hF0CF, 2'b11, 4'd4, 1'b0, 16'hFF0C, 5, 1'b0);
    do_op(16'hF0CF, 2'b10, 4'd4, 1'b0, 16'h0F0C, 5, 1'b0);
    do_op(16'h0001, 2'b01, 4'd15, 1'b0, 16'h8000, 16, 1'b1);
    do_op(16'h8000, 2'b11, 4'd15, 1'b0, 16'hFFFF, 16, 1'b0);
    do_op(16'hF0CF, 2'b01, 4'd0, 1'b0, 16'hF0CF, 1, 1'b0);
    do_op(16'hF0CF, 2'b01, 4'd4, 1'b1, ROT_EN ? 16'h0CFF : 16'h0CF0, 5, 1'b0);
    do_op(16'hF0CF, 2'b10, 4'd4, 1'b1, ROT_EN ? 16'hFF0C : 16'h0F0C, 5, 1'b0);
    do_op(16'hF0CF, 2'b11, 4'd4, 1'b1, 16'hFF0C, 5, 1'b0);

    // Asynchronous reset in the middle of a long shift.
    @(posedge clk); #1;
    start = 1'b1; in_d = 16'h0001; op_d = 2'b01; amt_d = 4'd15; rot_d = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sout", 32'(sout), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    do_op(16'hF0CF, 2'b01, 4'd1, 1'b0, 16'hE19E, 2, 1'b0);

    // Random traffic, including starts while busy and back-to-back starts.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      in_d  = 16'($urandom);
      op_d  = 2'($urandom);
      amt_d = 4'($urandom);
      rot_d = 1'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
